// File: rtl/bitwise_unit_arbiter.sv
// Round-robin arbiter in front of one shared bitwise logic unit (NOT/AND/OR/NAND).
// One request is granted per cycle; the result is held in an output register until accepted.
module bitwise_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [WIDTH-1:0]           rsp_data
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_reg;
    logic [ID_W-1:0]  rr_ptr_reg;
    logic [ID_W-1:0]  rr_ptr_next;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic [WIDTH-1:0] rsp_data_next;

    logic             can_accept;
    logic             found;
    logic [ID_W-1:0]  win_idx;
    logic             transfer;
    logic [WIDTH-1:0] lane_res [NUM_REQ];

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = ~a;
            2'b01:   r = a & b;
            2'b10:   r = a | b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

    // Every lane computes its candidate result; the winner's lane is muxed into the register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_res[gi] = logic_op(req_op[2*gi +: 2],
                                           req_a[gi*WIDTH +: WIDTH],
                                           req_b[gi*WIDTH +: WIDTH]);
            assign req_ready[gi] = rst_n & can_accept & found & (win_idx == ID_W'(gi));
        end
    endgenerate

    assign can_accept = (state_reg == EMPTY) | rsp_ready;

    always_comb begin
        logic [ID_W-1:0] idx;
        found   = 1'b0;
        win_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign transfer      = found & can_accept;
    assign rsp_data_next = lane_res[win_idx];
    assign rr_ptr_next   = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            rr_ptr_reg   <= '0;
            rsp_id_reg   <= '0;
            rsp_data_reg <= '0;
        end else if (transfer) begin
            // Covers both an empty register and a same-cycle drain plus refill.
            state_reg    <= FULL;
            rr_ptr_reg   <= rr_ptr_next;
            rsp_id_reg   <= win_idx;
            rsp_data_reg <= rsp_data_next;
        end else if (state_reg == FULL && rsp_ready) begin
            state_reg <= EMPTY;
        end
    end

    assign rsp_valid = (state_reg == FULL);
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_bitwise_unit_arbiter.sv
// Directed bench for bitwise_unit_arbiter: grants are checked each cycle and
// results flow through a scoreboard queue that is popped when the consumer accepts.
module tb_bitwise_unit_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    bitwise_unit_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'b00:   return ~a;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_lane(input int i, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        req_op[2*i +: 2] = op;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    // One clock cycle: check grant and valid at the falling edge, pop on consumer accept,
    // push the expected result of whichever requester the bench expects to be granted.
    task automatic cycle(input logic [N-1:0] exp_ready, input logic exp_valid);
        exp_t e;
        int   gid;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $error("FAIL sb_empty: observed unexpected rsp id=%0d data=%h expected none",
                       rsp_id, rsp_data);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                $display("rsp  id=%0d data=%h", rsp_id, rsp_data);
            end
        end
        if (exp_ready != '0) begin
            gid = 0;
            for (int i = 0; i < N; i++) if (exp_ready[i]) gid = i;
            e.id   = IW'(gid);
            e.data = ref_op(req_op[2*gid +: 2], req_a[gid*W +: W], req_b[gid*W +: W]);
            sb.push_back(e);
            $display("req  id=%0d op=%0d a=%h b=%h", gid, req_op[2*gid +: 2],
                     req_a[gid*W +: W], req_b[gid*W +: W]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        req_valid = '0;
        rst_n     = 1'b1;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;

        // Single requests: NOT then AND on requester 0
        req_valid = 4'b0001;
        set_lane(0, 2'b00, 16'h1234, 16'h5555);
        cycle(4'b0001, 1'b0);
        set_lane(0, 2'b01, 16'hAAAA, 16'h0F0F);
        cycle(4'b0001, 1'b1);
        req_valid = '0;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // Move pointer to 0 via requester 3, then all four continuously valid
        req_valid = 4'b1000;
        set_lane(3, 2'b11, 16'h00FF, 16'h0FF0);
        cycle(4'b1000, 1'b0);
        set_lane(0, 2'b00, 16'hC3C3, 16'h0000);
        set_lane(1, 2'b01, 16'h1357, 16'hFF00);
        set_lane(2, 2'b10, 16'h0101, 16'h8080);
        req_valid = 4'b1111;
        cycle(4'b0001, 1'b1);
        cycle(4'b0010, 1'b1);
        cycle(4'b0100, 1'b1);
        cycle(4'b1000, 1'b1);
        cycle(4'b0001, 1'b1);
        cycle(4'b0010, 1'b1);
        req_valid = '0;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // Backpressure: hold a result from requester 2 for three cycles
        req_valid = 4'b0100;
        set_lane(2, 2'b01, 16'hBEEF, 16'h0FF0);
        cycle(4'b0100, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        repeat (3) begin
            cycle(4'b0000, 1'b1);
            check("hold_data", 32'(rsp_data), 32'h0EE0);
            check("hold_id", 32'(rsp_id), 32'd2);
        end
        rsp_ready = 1'b1;
        cycle(4'b1000, 1'b1);
        req_valid = '0;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // Wrap: requester 2 OR sets pointer to 3; then req1/req3 contend
        req_valid = 4'b0100;
        set_lane(2, 2'b10, 16'hF000, 16'h000F);
        cycle(4'b0100, 1'b0);
        req_valid = 4'b1010;
        set_lane(1, 2'b00, 16'h0F0F, 16'h0000);
        set_lane(3, 2'b01, 16'hFFFF, 16'h1248);
        cycle(4'b1000, 1'b1);
        cycle(4'b0010, 1'b1);
        req_valid = '0;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // NAND edge cases
        req_valid = 4'b0001;
        set_lane(0, 2'b11, 16'hFFFF, 16'hFFFF);
        cycle(4'b0001, 1'b0);
        set_lane(0, 2'b11, 16'h0000, 16'h0000);
        cycle(4'b0001, 1'b1);
        req_valid = '0;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // Reset in the middle of a held result discards it and zeroes the pointer
        req_valid = 4'b0010;
        set_lane(1, 2'b01, 16'h5A5A, 16'hFFFF);
        cycle(4'b0010, 1'b0);
        check("pre_rst_valid", 32'(rsp_valid), 32'h1);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        sb.delete();
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_rsp_id", 32'(rsp_id), 32'h0);
        check("midrst_rsp_data", 32'(rsp_data), 32'h0);
        check("midrst_req_ready_rel", 32'(req_ready), 32'h0);
        req_valid = 4'b1111;
        cycle(4'b0001, 1'b0);
        req_valid = '0;
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
